// File: rtl/axis_sa_mm_engine.sv
// Runtime-sized AXIS matrix multiply C = A x B. A and B are buffered whole,
// then a Q-lane MAC array produces C one column group at a time.

module axis_sa_mac_lane #(
  parameter int DW = 8,
  parameter int AW = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 first,
  input  logic                 mask,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   term;

  assign prod = a * b;

  always_comb begin
    term = '0;
    if (!mask) term = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  end

  // First MAC cycle loads instead of accumulating, so no separate clear cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= first ? term : acc + term;
  end
endmodule

module axis_sa_mm_engine #(
  parameter int DW    = 8,
  parameter int OW    = 16,
  parameter int Q     = 8,
  parameter int MAX_M = 32,
  parameter int MAX_N = 32,
  parameter int MAX_L = 32,
  parameter int SAT   = 1,
  localparam int MW   = $clog2(MAX_M+1),
  localparam int NW   = $clog2(MAX_N+1),
  localparam int LW   = $clog2(MAX_L+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] cfg_m,
  input  logic [NW-1:0] cfg_n,
  input  logic [LW-1:0] cfg_l,
  output logic          busy,
  output logic          done,
  output logic          err_cfg,
  output logic          err_tlast,
  input  logic [DW-1:0] s_axis_a_tdata,
  input  logic          s_axis_a_tvalid,
  output logic          s_axis_a_tready,
  input  logic          s_axis_a_tlast,
  input  logic [DW-1:0] s_axis_b_tdata,
  input  logic          s_axis_b_tvalid,
  output logic          s_axis_b_tready,
  input  logic          s_axis_b_tlast,
  output logic [OW-1:0] m_axis_c_tdata,
  output logic          m_axis_c_tvalid,
  input  logic          m_axis_c_tready,
  output logic          m_axis_c_tlast
);
  localparam int AW = 2*DW + $clog2(MAX_N);
  localparam int CW = $clog2(MAX_M + MAX_N + MAX_L + Q + 1);
  localparam int MI = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int NI = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int LI = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] ONE   = 1;
  localparam logic [CW-1:0] QSTEP = Q;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MAC, EMIT} state_t;
  state_t state, state_nx;

  logic [CW-1:0] m_r, n_r, l_r, ld_r, ld_c, row_i, kk, gbase, lane_j;
  logic signed [DW-1:0] a_buf [MAX_M][MAX_N];
  logic signed [DW-1:0] b_buf [MAX_N][MAX_L];
  logic [Q-1:0][AW-1:0] acc;
  logic signed [AW-1:0] acc_sel;

  logic cfg_ok, a_fire, b_fire, c_fire, a_last, b_last, k_last;
  logic lane_last, grp_last, row_last;

  assign cfg_ok = (cfg_m != '0) && (cfg_m <= MW'(MAX_M)) &&
                  (cfg_n != '0) && (cfg_n <= NW'(MAX_N)) &&
                  (cfg_l != '0) && (cfg_l <= LW'(MAX_L));
  assign a_fire    = s_axis_a_tvalid && s_axis_a_tready;
  assign b_fire    = s_axis_b_tvalid && s_axis_b_tready;
  assign c_fire    = m_axis_c_tvalid && m_axis_c_tready;
  assign a_last    = (ld_r == m_r - ONE) && (ld_c == n_r - ONE);
  assign b_last    = (ld_r == n_r - ONE) && (ld_c == l_r - ONE);
  assign k_last    = (kk == n_r - ONE);
  assign lane_last = (lane_j == QSTEP - ONE) || (gbase + lane_j + ONE == l_r);
  assign grp_last  = (gbase + QSTEP >= l_r);
  assign row_last  = (row_i == m_r - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    s_axis_a_tready = 1'b0;
    s_axis_b_tready = 1'b0;
    m_axis_c_tvalid = 1'b0;
    case (state)
      IDLE:   if (start && cfg_ok) state_nx = LOAD_A;
      LOAD_A: begin
        s_axis_a_tready = 1'b1;
        if (s_axis_a_tvalid && a_last) state_nx = LOAD_B;
      end
      LOAD_B: begin
        s_axis_b_tready = 1'b1;
        if (s_axis_b_tvalid && b_last) state_nx = MAC;
      end
      MAC:    if (k_last) state_nx = EMIT;
      EMIT: begin
        m_axis_c_tvalid = 1'b1;
        if (m_axis_c_tready && lane_last)
          state_nx = (grp_last && row_last) ? IDLE : MAC;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign m_axis_c_tlast = m_axis_c_tvalid && lane_last && grp_last && row_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r <= '0; n_r <= '0; l_r <= '0;
      ld_r <= '0; ld_c <= '0; row_i <= '0; kk <= '0; gbase <= '0; lane_j <= '0;
      done <= 1'b0; err_cfg <= 1'b0; err_tlast <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cfg_ok) begin
            m_r <= CW'(cfg_m); n_r <= CW'(cfg_n); l_r <= CW'(cfg_l);
            ld_r <= '0; ld_c <= '0;
            err_cfg <= 1'b0; err_tlast <= 1'b0;
          end else begin
            err_cfg <= 1'b1;
          end
        end
        LOAD_A: if (a_fire) begin
          if (s_axis_a_tlast != a_last) err_tlast <= 1'b1;
          if (a_last) begin
            ld_r <= '0; ld_c <= '0;
          end else if (ld_c == n_r - ONE) begin
            ld_r <= ld_r + ONE; ld_c <= '0;
          end else begin
            ld_c <= ld_c + ONE;
          end
        end
        LOAD_B: if (b_fire) begin
          if (s_axis_b_tlast != b_last) err_tlast <= 1'b1;
          if (b_last) begin
            ld_r <= '0; ld_c <= '0; row_i <= '0; gbase <= '0; kk <= '0;
          end else if (ld_c == l_r - ONE) begin
            ld_r <= ld_r + ONE; ld_c <= '0;
          end else begin
            ld_c <= ld_c + ONE;
          end
        end
        MAC: begin
          kk <= k_last ? '0 : kk + ONE;
          if (k_last) lane_j <= '0;
        end
        EMIT: if (c_fire) begin
          if (lane_last) begin
            lane_j <= '0;
            if (grp_last) begin
              gbase <= '0;
              if (row_last) done  <= 1'b1;
              else          row_i <= row_i + ONE;
            end else begin
              gbase <= gbase + QSTEP;
            end
          end else begin
            lane_j <= lane_j + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers need no reset: the load counters always overwrite before use.
  always_ff @(posedge clk) begin
    if (a_fire) a_buf[ld_r[MI-1:0]][ld_c[NI-1:0]] <= s_axis_a_tdata;
    if (b_fire) b_buf[ld_r[NI-1:0]][ld_c[LI-1:0]] <= s_axis_b_tdata;
  end

  for (genvar j = 0; j < Q; j++) begin : g_lane
    logic [CW-1:0] col;
    assign col = gbase + CW'(j);
    axis_sa_mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (state == MAC),
      .first (kk == '0),
      .mask  (col >= l_r),
      .a     (a_buf[row_i[MI-1:0]][kk[NI-1:0]]),
      .b     (b_buf[kk[NI-1:0]][col[LI-1:0]]),
      .acc   (acc[j])
    );
  end

  assign acc_sel = acc[lane_j[QW-1:0]];

  if (SAT != 0 && AW > OW) begin : g_sat
    localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    always_comb begin
      m_axis_c_tdata = acc_sel[OW-1:0];
      if (acc_sel > OMAX)      m_axis_c_tdata = OMAX[OW-1:0];
      else if (acc_sel < OMIN) m_axis_c_tdata = OMIN[OW-1:0];
    end
  end else begin : g_trunc
    assign m_axis_c_tdata = OW'(acc_sel);
  end
endmodule

// File: tb/tb_axis_sa_mm_engine.sv
module tb_axis_sa_mm_engine;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [5:0] cfg_m = '0, cfg_n = '0, cfg_l = '0;
  logic busy, done, err_cfg, err_tlast;
  logic [7:0] a_tdata = '0, b_tdata = '0;
  logic a_tvalid = 1'b0, a_tlast = 1'b0, b_tvalid = 1'b0, b_tlast = 1'b0;
  logic a_tready, b_tready;
  logic [15:0] c_tdata;
  logic c_tvalid, c_tlast, c_tready = 1'b0;
  logic ns_busy, ns_done, ns_err_cfg, ns_err_tlast, ns_a_tready, ns_b_tready;
  logic ns_c_tvalid, ns_c_tlast;
  logic [15:0] ns_c_tdata;

  int checks = 0, failures = 0;
  logic signed [7:0] av [0:63];
  logic signed [7:0] bv [0:63];
  logic [15:0] ex [0:63];
  logic [15:0] exn [0:63];
  logic [15:0] cd [0:63];
  logic [15:0] cns [0:63];
  logic        cl [0:63];

  always #5 clk = ~clk;

  axis_sa_mm_engine #(.SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_l(cfg_l),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_tlast(err_tlast),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready), .s_axis_a_tlast(a_tlast),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready), .s_axis_b_tlast(b_tlast),
    .m_axis_c_tdata(c_tdata), .m_axis_c_tvalid(c_tvalid), .m_axis_c_tready(c_tready), .m_axis_c_tlast(c_tlast));

  axis_sa_mm_engine #(.SAT(0)) dut_ns (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_l(cfg_l),
    .busy(ns_busy), .done(ns_done), .err_cfg(ns_err_cfg), .err_tlast(ns_err_tlast),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(ns_a_tready), .s_axis_a_tlast(a_tlast),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(ns_b_tready), .s_axis_b_tlast(b_tlast),
    .m_axis_c_tdata(ns_c_tdata), .m_axis_c_tvalid(ns_c_tvalid), .m_axis_c_tready(c_tready), .m_axis_c_tlast(ns_c_tlast));

  task automatic fail(input string tag);
    failures++;
    $error("FAIL %s", tag);
  endtask

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic model(input int m, input int n, input int l);
    for (int i = 0; i < m; i++)
      for (int c = 0; c < l; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < n; k++) s += int'(av[i*n+k]) * int'(bv[k*l+c]);
        ex[i*l+c]  = sat16(s);
        exn[i*l+c] = s[15:0];
      end
  endtask

  task automatic do_start(input int m, input int n, input int l);
    cfg_m = 6'(m); cfg_n = 6'(n); cfg_l = 6'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input bit isb, input int cnt, input int badpos);
    bit timeout = 1'b0;
    for (int e = 0; e < cnt; e++) begin
      int w;
      logic rdy;
      w = 0;
      if (isb) begin
        b_tdata = bv[e]; b_tvalid = 1'b1;
        b_tlast = (badpos < 0) ? (e == cnt-1) : (e == badpos);
      end else begin
        a_tdata = av[e]; a_tvalid = 1'b1;
        a_tlast = (badpos < 0) ? (e == cnt-1) : (e == badpos);
      end
      do begin
        @(negedge clk);
        rdy = isb ? b_tready : a_tready;
        @(posedge clk); #1;
        w++;
      end while (!rdy && w < 100);
      if (!rdy) timeout = 1'b1;
    end
    a_tvalid = 1'b0; a_tlast = 1'b0; b_tvalid = 1'b0; b_tlast = 1'b0;
    checks++; if (timeout !== 1'b0) fail("load_timeout");
  endtask

  task automatic collect(input int nb, input bit stall);
    int got, cyc;
    bit holding;
    logic [15:0] hold_d;
    got = 0; cyc = 0; holding = 1'b0; hold_d = '0;
    while (got < nb && cyc < 4000) begin
      c_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (c_tvalid) begin
        if (holding) begin
          checks++; if (c_tdata !== hold_d) fail("c_hold");
        end
        if (c_tready) begin
          cd[got] = c_tdata; cns[got] = ns_c_tdata; cl[got] = c_tlast;
          got++; holding = 1'b0;
        end else begin
          holding = 1'b1; hold_d = c_tdata;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    c_tready = 1'b0;
    checks++; if (got !== nb) fail("c_beat_count");
    checks++; if (done !== 1'b1) fail("done_pulse");
    checks++; if (busy !== 1'b0) fail("busy_dropped");
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) fail("done_once");
    checks++; if (c_tvalid !== 1'b0) fail("no_extra_beat");
  endtask

  task automatic run_job(input int m, input int n, input int l, input int bad,
                         input bit stall, input logic exp_errt);
    model(m, n, l);
    do_start(m, n, l);
    checks++; if (busy !== 1'b1) fail("busy_after_start");
    checks++; if (err_cfg !== 1'b0) fail("err_cfg_cleared");
    checks++; if (err_tlast !== 1'b0) fail("err_tlast_cleared");
    load(1'b0, m*n, bad);
    load(1'b1, n*l, -1);
    collect(m*l, stall);
    checks++; if (err_tlast !== exp_errt) fail("err_tlast");
    for (int e = 0; e < m*l; e++) begin
      checks++; if (cd[e] !== ex[e]) fail("c_data_sat");
      checks++; if (cns[e] !== exn[e]) fail("c_data_trunc");
      checks++; if (cl[e] !== (e == m*l-1)) fail("c_tlast");
    end
  endtask

  task automatic set_t1();
    av[0] = 8'sd1; av[1] = 8'sd2; av[2] = 8'sd3; av[3] = 8'sd4;
    bv[0] = 8'sd5; bv[1] = 8'sd6; bv[2] = 8'sd7; bv[3] = 8'sd8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({busy, done, err_cfg, err_tlast} !== 4'b0000) fail("rst_ctrl");
    checks++; if ({a_tready, b_tready, c_tvalid, c_tlast} !== 4'b0000) fail("rst_stream");
    checks++; if (c_tdata !== 16'h0000) fail("rst_tdata");
    rst = 1'b0;
    @(posedge clk); #1;

    set_t1();
    run_job(2, 2, 2, -1, 1'b0, 1'b0);
    checks++; if (cd[0] !== 16'd19) fail("t1_c00");
    checks++; if (cd[1] !== 16'd22) fail("t1_c01");
    checks++; if (cd[2] !== 16'd43) fail("t1_c10");
    checks++; if (cd[3] !== 16'd50) fail("t1_c11");

    for (int e = 0; e < 15; e++) av[e] = 8'($urandom);
    for (int e = 0; e < 55; e++) bv[e] = 8'($urandom);
    run_job(3, 5, 11, -1, 1'b1, 1'b0);

    av[0] = 8'sd1; av[1] = -8'sd1; av[2] = 8'sd2; av[3] = 8'sd0;
    bv[0] = 8'sd3; bv[1] = 8'sd4;  bv[2] = 8'sd5; bv[3] = 8'sd6;
    run_job(2, 2, 2, 2, 1'b0, 1'b1);
    checks++; if (cd[0] !== 16'hfffe) fail("t4_c00");
    checks++; if (cd[3] !== 16'd8) fail("t4_c11");

    do_start(2, 0, 2);
    checks++; if (err_cfg !== 1'b1) fail("cfg_n0_err");
    checks++; if (busy !== 1'b0) fail("cfg_n0_busy");
    checks++; if ({a_tready, b_tready} !== 2'b00) fail("cfg_n0_ready");
    do_start(2, 2, 33);
    @(posedge clk); #1;
    checks++; if (err_cfg !== 1'b1) fail("cfg_l33_err");
    checks++; if (busy !== 1'b0) fail("cfg_l33_busy");
    checks++; if ({a_tready, b_tready} !== 2'b00) fail("cfg_l33_ready");

    for (int e = 0; e < 4; e++) begin av[e] = -8'sd128; bv[e] = -8'sd128; end
    run_job(1, 4, 1, -1, 1'b0, 1'b0);
    checks++; if (cd[0] !== 16'h7fff) fail("t3_sat");
    checks++; if (cns[0] !== 16'h0000) fail("t3_trunc");

    for (int e = 0; e < 4; e++) begin av[e] = 8'sd9; bv[e] = 8'sd9; end
    do_start(2, 2, 2);
    load(1'b0, 4, -1);
    load(1'b1, 4, -1);
    begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!c_tvalid && w < 100);
    end
    checks++; if (c_tvalid !== 1'b1) fail("t6_in_emit");
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, err_cfg, err_tlast} !== 4'b0000) fail("t6_rst_ctrl");
    checks++; if ({a_tready, b_tready, c_tvalid, c_tlast} !== 4'b0000) fail("t6_rst_stream");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_t1();
    run_job(2, 2, 2, -1, 1'b0, 1'b0);
    checks++; if (cd[0] !== 16'd19) fail("t6_c00");
    checks++; if (cd[3] !== 16'd50) fail("t6_c11");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
